md_unit: RTL

Multiply/divide unit for the E stage of the pipelined MIPS core, alongside the ALU. It accepts `mult`/`multu`/`div`/`divu` operands from the E-stage forwarding muxes and produces the 64-bit result into architectural HI/LO after a fixed multi-cycle latency. It also services `mthi`/`mtlo` writes and supplies HI/LO to the E→M pipeline register for `mfhi`/`mflo`. It exports `busy`, which the hazard unit combines with `start` to stall any MD-class instruction in D.

---
 rtl/md_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : E-stage multiply/divide unit owning architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W        = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);
  localparam int BITS_PER_CYC = (32 + DIV_CYCLES - 1) / DIV_CYCLES;

  localparam logic [CNT_W-1:0] C_MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_pend_hi;
  logic [31:0]       r_pend_lo;
  logic              r_is_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [31:0]       r_rem;
  logic [31:0]       r_quo;
  logic [31:0]       r_dvs;
  logic [5:0]        r_bits_left;

  logic              w_is_div;
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [31:0]       w_a_mag;
  logic [31:0]       w_b_mag;
  logic              w_div_zero;
  logic signed [63:0] w_prod_s;
  logic [63:0]       w_prod_u;

  logic [32:0]       w_trial;
  logic [31:0]       w_rem_nx;
  logic [31:0]       w_quo_nx;
  logic [5:0]        w_bits_nx;
  logic [31:0]       w_div_hi;
  logic [31:0]       w_div_lo;

  assign w_is_div   = md_op[1];
  assign w_signed   = ~md_op[0];
  assign w_a_neg    = w_signed & A[31];
  assign w_b_neg    = w_signed & B[31];
  assign w_a_mag    = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag    = w_b_neg ? (~B + 32'd1) : B;
  assign w_div_zero = (B == 32'd0);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Restoring divider on magnitudes, several quotient bits per clock so that
  // all 32 bits are resolved no later than the commit edge.
  always_comb begin
    w_rem_nx  = r_rem;
    w_quo_nx  = r_quo;
    w_bits_nx = r_bits_left;
    w_trial   = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (w_bits_nx != 6'd0) begin
        w_trial = {w_rem_nx, w_quo_nx[31]};
        if (w_trial >= {1'b0, r_dvs}) begin
          w_trial  = w_trial - {1'b0, r_dvs};
          w_quo_nx = {w_quo_nx[30:0], 1'b1};
        end else begin
          w_quo_nx = {w_quo_nx[30:0], 1'b0};
        end
        w_rem_nx  = w_trial[31:0];
        w_bits_nx = w_bits_nx - 6'd1;
      end
    end
  end

  // Quotient sign follows the operand signs, remainder follows the dividend.
  assign w_div_lo = r_neg_q ? (~w_quo_nx + 32'd1) : w_quo_nx;
  assign w_div_hi = r_neg_r ? (~w_rem_nx + 32'd1) : w_rem_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      busy        <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_bits_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt   <= w_is_div ? C_DIV_N : C_MULT_N;
            busy    <= 1'b1;
            r_state <= S_RUN;
            if (!w_is_div) begin
              r_is_div               <= 1'b0;
              r_bits_left            <= '0;
              {r_pend_hi, r_pend_lo} <= w_signed ? w_prod_s : w_prod_u;
            end else if (w_div_zero) begin
              r_is_div    <= 1'b0;
              r_bits_left <= '0;
              r_pend_hi   <= A;
              r_pend_lo   <= '1;
            end else begin
              r_is_div    <= 1'b1;
              r_rem       <= '0;
              r_quo       <= w_a_mag;
              r_dvs       <= w_b_mag;
              r_bits_left <= 6'd32;
              r_neg_q     <= w_a_neg ^ w_b_neg;
              r_neg_r     <= w_a_neg;
            end
          end else begin
            if (hi_we) HI <= wdata;
            if (lo_we) LO <= wdata;
          end
        end
        S_RUN: begin
          r_rem       <= w_rem_nx;
          r_quo       <= w_quo_nx;
          r_bits_left <= w_bits_nx;
          if (r_cnt == C_ONE) begin
            HI      <= r_is_div ? w_div_hi : r_pend_hi;
            LO      <= r_is_div ? w_div_lo : r_pend_lo;
            busy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
